snn_inference_sequencer: RTL and testbench

SNN_INFERENCE_SEQUENCER -- requirements
Module: snn_inference_sequencer

---
 rtl/snn_pkg.sv | 16 +
 rtl/spike_argmax.sv | 24 ++
 rtl/snn_inference_sequencer.sv | 116 +++++++++++
 tb/tb_snn_inference_sequencer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// snn_pkg: shared sequencer state encoding and network-size defaults.
package snn_pkg;

    localparam int N_CLASSES_DEF = 10;
    localparam int T_STEPS_DEF   = 16;
    localparam int PIPE_LAT_DEF  = 3;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/spike_argmax.sv
// spike_argmax: combinational argmax over spike counts; ties go to the lowest index.
module spike_argmax #(
    parameter int N_CLASSES = 10,
    parameter int CNT_W     = 5
) (
    input  logic [N_CLASSES-1:0][CNT_W-1:0] i_cnt,
    output logic [$clog2(N_CLASSES)-1:0]    o_class,
    output logic [CNT_W-1:0]                o_count
);

    localparam int IDX_W = $clog2(N_CLASSES);

    always_comb begin
        o_class = '0;
        o_count = i_cnt[0];
        for (int i = 1; i < N_CLASSES; i++) begin
            if (i_cnt[i] > o_count) begin
                o_class = IDX_W'(i);
                o_count = i_cnt[i];
            end
        end
    end

endmodule

// File: rtl/snn_inference_sequencer.sv
// snn_inference_sequencer: runs one SNN inference (clear, run, drain) and reports the winning class.
// Optional early exit on a class reaching EXIT_THRESH is enabled by defining SNN_EARLY_EXIT_EN.
module snn_inference_sequencer
    import snn_pkg::*;
#(
    parameter int N_CLASSES = N_CLASSES_DEF,
    parameter int T_STEPS   = T_STEPS_DEF,
    parameter int PIPE_LAT  = PIPE_LAT_DEF,
    parameter int CNT_W     = $clog2(T_STEPS + 1)
`ifdef SNN_EARLY_EXIT_EN
    ,
    parameter int EXIT_THRESH = 8
`endif
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start_valid,
    output logic                         start_ready,
    output logic                         net_rst_n,
    output logic                         net_ce,
    output logic                         x_en,
    input  logic [N_CLASSES-1:0]         spike_in,
    output logic                         result_valid,
    input  logic                         result_ready,
    output logic [$clog2(N_CLASSES)-1:0] result_class,
    output logic [CNT_W-1:0]             result_count
);

    localparam logic [7:0] STEP_LAST  = 8'(T_STEPS - 1);
    localparam logic [7:0] DRAIN_LAST = 8'(PIPE_LAT - 1);
    localparam logic [7:0] WIN_FIRST  = 8'(PIPE_LAT);

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [7:0]                      r_step;
    logic [7:0]                      r_drain;
    logic [N_CLASSES-1:0][CNT_W-1:0] r_cnt;
    logic [N_CLASSES-1:0][CNT_W-1:0] w_cnt_nxt;
    logic [$clog2(N_CLASSES)-1:0]    r_class;
    logic [CNT_W-1:0]                r_count;
    logic [$clog2(N_CLASSES)-1:0]    w_am_class;
    logic [CNT_W-1:0]                w_am_count;
    logic                            w_win;
    logic                            w_exit;

    // Output spikes lag inputs by PIPE_LAT, so the window is the run shifted by that latency.
    assign w_win = (r_state == RUN && r_step >= WIN_FIRST) ||
                   (r_state == DRAIN && ({1'b0, r_drain} + 9'(T_STEPS)) >= 9'(PIPE_LAT));

    for (genvar g = 0; g < N_CLASSES; g++) begin : g_cnt
        assign w_cnt_nxt[g] = (w_win && spike_in[g] && r_cnt[g] != '1) ? r_cnt[g] + 1'b1 : r_cnt[g];
    end

`ifdef SNN_EARLY_EXIT_EN
    localparam logic [CNT_W-1:0] THR = CNT_W'(EXIT_THRESH);
    logic [N_CLASSES-1:0] w_ge;
    for (genvar g = 0; g < N_CLASSES; g++) begin : g_thr
        assign w_ge[g] = w_cnt_nxt[g] >= THR;
    end
    assign w_exit = w_win && |w_ge;
`else
    assign w_exit = 1'b0;
`endif

    // Argmax sees next-cycle counts so the last window cycle is included in the result.
    spike_argmax #(
        .N_CLASSES(N_CLASSES),
        .CNT_W    (CNT_W)
    ) u_argmax (
        .i_cnt  (w_cnt_nxt),
        .o_class(w_am_class),
        .o_count(w_am_count)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = start_valid ? CLEAR : IDLE;
            CLEAR:   w_state_nxt = RUN;
            RUN:     w_state_nxt = (r_step == STEP_LAST) ? DRAIN : RUN;
            DRAIN:   w_state_nxt = (r_drain == DRAIN_LAST) ? DONE : DRAIN;
            DONE:    w_state_nxt = result_ready ? IDLE : DONE;
            default: w_state_nxt = IDLE;
        endcase
        if (w_exit) w_state_nxt = DONE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_step  <= '0;
            r_drain <= '0;
            r_cnt   <= '0;
            r_class <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= (r_state == RUN && w_state_nxt == RUN) ? r_step + 8'd1 : '0;
            r_drain <= (r_state == DRAIN && w_state_nxt == DRAIN) ? r_drain + 8'd1 : '0;
            r_cnt   <= (r_state == IDLE && start_valid) ? '0 : w_cnt_nxt;
            if (w_state_nxt == DONE && r_state != DONE) begin
                r_class <= w_am_class;
                r_count <= w_am_count;
            end
        end
    end

    assign start_ready  = r_state == IDLE;
    assign net_rst_n    = rst_n && r_state != CLEAR;
    assign net_ce       = r_state == RUN || r_state == DRAIN;
    assign x_en         = r_state == RUN;
    assign result_valid = r_state == DONE;
    assign result_class = r_class;
    assign result_count = r_count;

endmodule

// File: tb/tb_snn_inference_sequencer.sv
// tb_snn_inference_sequencer: table-driven spike patterns with a result scoreboard plus reset/handshake sequences.
module tb_snn_inference_sequencer;

    logic       clk = 0;
    logic       rst_n = 0;
    logic       start_valid = 0;
    logic       start_ready;
    logic       net_rst_n;
    logic       net_ce;
    logic       x_en;
    logic [9:0] spike_in = '0;
    logic       result_valid;
    logic       result_ready = 0;
    logic [3:0] result_class;
    logic [4:0] result_count;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [9:0] mask;
        int         lo;
        int         hi;
        int         cls;
        int         cnt;
        int         lat;
    } vec_t;

    typedef struct {
        int cls;
        int cnt;
        int lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[7];

    snn_inference_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .net_rst_n   (net_rst_n),
        .net_ce      (net_ce),
        .x_en        (x_en),
        .spike_in    (spike_in),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .result_class(result_class),
        .result_count(result_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] pat(input vec_t v, input int k);
        return (k >= v.lo && k <= v.hi) ? v.mask : 10'd0;
    endfunction

    // Cycle k=0 is the handshake cycle; CLEAR is k=1, RUN k=2..17, DRAIN k=18..20.
    task automatic run(input vec_t v, input int hold);
        exp_t e;
        bit   seen;
        seen = 0;
        @(negedge clk);
        chk("start_ready_idle", start_ready, 1);
        start_valid = 1;
        spike_in = pat(v, 0);
        sb.push_back('{v.cls, v.cnt, v.lat});
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            start_valid = 0;
            if (result_valid) begin
                seen = 1;
                e = sb.pop_front();
                chk("latency", k, e.lat);
                chk("class", result_class, e.cls);
                chk("count", result_count, e.cnt);
                chk("ctl_done", {net_rst_n, net_ce, x_en}, 3'b100);
                spike_in = 10'h3ff;
                for (int h = 0; h < hold; h++) begin
                    result_ready = 0;
                    start_valid = 1;
                    @(negedge clk);
                    chk("hold_valid", result_valid, 1);
                    chk("hold_class", result_class, e.cls);
                    chk("hold_count", result_count, e.cnt);
                    chk("hold_start_ready", start_ready, 0);
                end
                start_valid = 0;
                result_ready = 1;
                @(negedge clk);
                result_ready = 0;
                spike_in = '0;
                chk("idle_after_ack", {start_ready, result_valid}, 2'b10);
            end else begin
                spike_in = pat(v, k);
                chk("ctl_busy", {net_rst_n, net_ce, x_en},
                    k == 1 ? 3'b000 : (k <= 17 ? 3'b111 : 3'b110));
                chk("start_ready_busy", start_ready, 0);
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL timeout no result_valid within 40 cycles");
            void'(sb.pop_front());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef SNN_EARLY_EXIT_EN
        vecs[0] = '{10'h080, 5, 20, 7, 8, 13};
        vecs[1] = '{10'h024, 5, 13, 2, 8, 13};
        vecs[5] = '{10'h042, 10, 30, 1, 8, 18};
        vecs[6] = '{10'h008, 5, 20, 3, 8, 13};
`else
        vecs[0] = '{10'h080, 5, 20, 7, 16, 21};
        vecs[1] = '{10'h024, 5, 13, 2, 9, 21};
        vecs[5] = '{10'h042, 10, 30, 1, 11, 21};
        vecs[6] = '{10'h008, 0, 30, 3, 16, 21};
`endif
        vecs[2] = '{10'h3ff, 2, 4, 0, 0, 21};
        vecs[3] = '{10'h200, 4, 5, 9, 1, 21};
        vecs[4] = '{10'h010, 20, 21, 4, 1, 21};

        repeat (2) @(negedge clk);
        chk("rst_start_ready", start_ready, 1);
        chk("rst_net_rst_n", net_rst_n, 0);
        chk("rst_net_ce", net_ce, 0);
        chk("rst_x_en", x_en, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_result_class", result_class, 0);
        chk("rst_result_count", result_count, 0);
        rst_n = 1;
        @(negedge clk);
        chk("idle_net_rst_n", net_rst_n, 1);
        start_valid = 0;

        for (int i = 0; i < 7; i++) run(vecs[i], 0);

        run(vecs[0], 10);

        // Reset during RUN step 5 (k=7), then a fresh full run.
        @(negedge clk);
        start_valid = 1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            start_valid = 0;
            spike_in = (k >= 5) ? 10'h100 : 10'h000;
        end
        rst_n = 0;
        @(negedge clk);
        chk("midrun_rst_start_ready", start_ready, 1);
        chk("midrun_rst_ctl", {net_rst_n, net_ce, x_en}, 3'b000);
        chk("midrun_rst_valid", result_valid, 0);
        chk("midrun_rst_count", result_count, 0);
        rst_n = 1;
        spike_in = '0;
        run(vecs[2], 0);
        run(vecs[0], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
